// File: rtl/magma_block_ctrl.sv
// rtl/magma_block_ctrl.sv - Magma 64-bit block round sequencer
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   key_valid/key_ready/key_in  256-bit key load, K0=key_in[255:224] .. K7=key_in[31:0]
//   in_valid/in_ready           block handshake with in_mode (0=enc, 1=dec) and in_data
//   rnd_req/rnd_a/rnd_key       round request to the external S-box/rotate core
//   rnd_idx/rnd_res             current round number, core result g_k(a0)
//   out_valid/out_ready         result handshake carrying out_data
//   busy                        controller not idle
module magma_block_ctrl #(
   parameter int CORE_LAT = 0
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [255:0] key_in,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [63:0]  in_data,
   output logic         rnd_req,
   output logic [31:0]  rnd_a,
   output logic [31:0]  rnd_key,
   output logic [4:0]   rnd_idx,
   input  logic [31:0]  rnd_res,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

   localparam logic [7:0] LAT = 8'(CORE_LAT);

   state_t        r_state;
   state_t        w_next;
   logic [255:0]  r_key;
   logic          r_key_loaded;
   logic          r_mode;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [4:0]    r_idx;
   logic [63:0]   r_out_data;
   logic          r_out_valid;
   logic [7:0]    r_cnt;

   logic          w_in_fire;
   logic          w_sample;
   logic          w_last;
   logic          w_rev;
   logic [2:0]    w_sel;

   assign key_ready = (r_state == S_IDLE);
   assign in_ready  = (r_state == S_IDLE) && r_key_loaded;
   assign busy      = (r_state != S_IDLE);
   assign rnd_req   = (r_state == S_REQ);
   assign rnd_a     = r_lo;
   assign rnd_idx   = r_idx;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   // in_ready uses the registered key_loaded, so a key arriving in the same
   // cycle as a block only takes effect for the following cycle.
   assign w_in_fire = in_ready && in_valid;
   assign w_last    = (r_idx == 5'd31);

   // Encrypt walks K0..K7 three times then reverses; decrypt walks forward
   // once then reverses three times. Reversal is 7-(i mod 8) = ~i[2:0].
   always_comb begin
      w_rev = r_mode ? (r_idx[4:3] != 2'd0) : (r_idx[4:3] == 2'd3);
      w_sel = w_rev ? ~r_idx[2:0] : r_idx[2:0];
   end

   // K0 sits in the top word, so word w starts at bit (7-w)*32 = {~w,5'b0}.
   assign rnd_key = r_key[{~w_sel, 5'd0} +: 32];

   // Combinational core is sampled in REQ; otherwise on the last WAIT cycle.
   assign w_sample = ((r_state == S_REQ) && (LAT == 8'd0)) ||
                     ((r_state == S_WAIT) && (r_cnt == LAT));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_in_fire) w_next = S_REQ;
         S_REQ: begin
            if (LAT != 8'd0)   w_next = S_WAIT;
            else if (w_last)   w_next = S_OUT;
            else               w_next = S_REQ;
         end
         S_WAIT: if (w_sample) w_next = w_last ? S_OUT : S_REQ;
         S_OUT:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_key        <= '0;
         r_key_loaded <= 1'b0;
         r_mode       <= 1'b0;
         r_hi         <= '0;
         r_lo         <= '0;
         r_idx        <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_next;

         if (key_valid && (r_state == S_IDLE)) begin
            r_key        <= key_in;
            r_key_loaded <= 1'b1;
         end

         if (w_in_fire) begin
            r_hi   <= in_data[63:32];
            r_lo   <= in_data[31:0];
            r_mode <= in_mode;
            r_idx  <= 5'd0;
         end

         if (r_state == S_REQ)
            r_cnt <= 8'd1;
         else if ((r_state == S_WAIT) && !w_sample)
            r_cnt <= r_cnt + 8'd1;

         if (w_sample) begin
            if (w_last) begin
               // Final round is not swapped.
               r_out_data  <= {rnd_res ^ r_hi, r_lo};
               r_out_valid <= 1'b1;
            end else begin
               r_hi  <= r_lo;
               r_lo  <= rnd_res ^ r_hi;
               r_idx <= r_idx + 5'd1;
            end
         end

         if ((r_state == S_OUT) && out_ready)
            r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_magma_block_ctrl.sv
// tb/tb_magma_block_ctrl.sv - self-checking bench for magma_block_ctrl
module tb_magma_block_ctrl;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;
   logic RST;

   logic         a_key_valid, a_key_ready, a_in_valid, a_in_ready, a_in_mode;
   logic [255:0] a_key_in;
   logic [63:0]  a_in_data, a_out_data;
   logic         a_rnd_req, a_out_valid, a_out_ready, a_busy;
   logic [31:0]  a_rnd_a, a_rnd_key, a_rnd_res;
   logic [4:0]   a_rnd_idx;

   logic         b_key_valid, b_key_ready, b_in_valid, b_in_ready, b_in_mode;
   logic [255:0] b_key_in;
   logic [63:0]  b_in_data, b_out_data;
   logic         b_rnd_req, b_out_valid, b_out_ready, b_busy;
   logic [31:0]  b_rnd_a, b_rnd_key, b_rnd_res;
   logic [4:0]   b_rnd_idx;

   magma_block_ctrl #(.CORE_LAT(0)) dut0 (
      .CLK(CLK), .RST(RST),
      .key_valid(a_key_valid), .key_ready(a_key_ready), .key_in(a_key_in),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
      .rnd_req(a_rnd_req), .rnd_a(a_rnd_a), .rnd_key(a_rnd_key), .rnd_idx(a_rnd_idx),
      .rnd_res(a_rnd_res),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .busy(a_busy)
   );

   magma_block_ctrl #(.CORE_LAT(3)) dut3 (
      .CLK(CLK), .RST(RST),
      .key_valid(b_key_valid), .key_ready(b_key_ready), .key_in(b_key_in),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
      .rnd_req(b_rnd_req), .rnd_a(b_rnd_a), .rnd_key(b_rnd_key), .rnd_idx(b_rnd_idx),
      .rnd_res(b_rnd_res),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .busy(b_busy)
   );

   // Round core: modular add; the 3-cycle core only shows the true sum on its last cycle.
   assign a_rnd_res = a_rnd_a + a_rnd_key;
   int b_lat_cnt = 0;
   always @(posedge CLK) begin
      if (RST)                              b_lat_cnt <= 0;
      else if (b_rnd_req)                   b_lat_cnt <= 1;
      else if (b_lat_cnt > 0 && b_lat_cnt < 3) b_lat_cnt <= b_lat_cnt + 1;
      else                                  b_lat_cnt <= 0;
   end
   assign b_rnd_res = (b_lat_cnt == 3) ? (b_rnd_a + b_rnd_key) : ~(b_rnd_a + b_rnd_key);

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   logic [31:0] a_keys[$];
   int a_req_n = 0;
   always @(negedge CLK) begin
      if (a_rnd_req) begin
         a_keys.push_back(a_rnd_key);
         a_req_n <= a_req_n + 1;
      end
   end

   int b_req_n = 0, b_gap_bad = 0, b_unstable = 0, b_last_req = -1;
   logic [31:0] b_held_a = '0, b_held_k = '0;
   always @(negedge CLK) begin
      if (b_rnd_req) begin
         b_req_n <= b_req_n + 1;
         if (b_last_req >= 0 && (cyc - b_last_req) != 4) b_gap_bad <= b_gap_bad + 1;
         b_last_req <= cyc;
         b_held_a   <= b_rnd_a;
         b_held_k   <= b_rnd_key;
      end else if (b_busy && !b_out_valid) begin
         if (b_rnd_a !== b_held_a || b_rnd_key !== b_held_k) b_unstable <= b_unstable + 1;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] kword(input logic [255:0] key, input int j);
      return key[255 - 32*j -: 32];
   endfunction

   function automatic int ksel(input logic mode, input int i);
      if (mode) return (i < 8) ? i : 7 - (i % 8);
      return (i < 24) ? (i % 8) : 7 - (i % 8);
   endfunction

   function automatic logic [63:0] ref_block(input logic [255:0] key, input logic mode,
                                             input logic [63:0] blk);
      logic [31:0] a1, a0, g, t;
      a1 = blk[63:32];
      a0 = blk[31:0];
      for (int i = 0; i < 32; i++) begin
         g = a0 + kword(key, ksel(mode, i));
         if (i == 31) return {g ^ a1, a0};
         t  = a0;
         a0 = g ^ a1;
         a1 = t;
      end
      return 64'h0;
   endfunction

   function automatic int keyseq_errors(input logic [255:0] key, input logic mode, input int base);
      int e;
      e = 0;
      for (int i = 0; i < 32; i++) begin
         if (base + i >= a_keys.size()) e++;
         else if (a_keys[base + i] !== kword(key, ksel(mode, i))) e++;
      end
      return e;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_key0(input logic [255:0] k);
      a_key_valid = 1'b1;
      a_key_in    = k;
      step();
      a_key_valid = 1'b0;
   endtask

   task automatic run0(input logic mode, input logic [63:0] data, input bit consume,
                       output logic [63:0] res, output int lat);
      int n;
      n = 0;
      while (!a_in_ready && n < 50) begin step(); n++; end
      check1("in_ready_before_block", a_in_ready, 1'b1);
      a_in_valid = 1'b1;
      a_in_mode  = mode;
      a_in_data  = data;
      step();
      a_in_valid = 1'b0;
      lat = 0;
      while (!a_out_valid && lat < 200) begin step(); lat++; end
      res = a_out_data;
      if (consume) begin
         a_out_ready = 1'b1;
         step();
         a_out_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic        mode;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] key_a, key_r;
      logic [63:0]  res, exp, enc0;
      int           lat, base, n, bad_d, bad_v, bad_r;
      vec_t         vt[6];

      for (int i = 0; i < 8; i++) key_a[255 - 32*i -: 32] = 32'(32'h11111111 * (i + 1));
      enc0 = ref_block(key_a, 1'b0, 64'h0);
      vt[0] = '{1'b0, 64'h0, enc0};
      vt[1] = '{1'b1, enc0, 64'h0};
      vt[2] = '{1'b0, 64'h0123456789ABCDEF, ref_block(key_a, 1'b0, 64'h0123456789ABCDEF)};
      vt[3] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, ref_block(key_a, 1'b1, 64'hFFFFFFFFFFFFFFFF)};
      for (int i = 4; i < 6; i++) begin
         vt[i].mode = 1'($urandom_range(0, 1));
         vt[i].data = {$urandom, $urandom};
         vt[i].exp  = ref_block(key_a, vt[i].mode, vt[i].data);
      end

      a_key_valid = 0; a_key_in = '0; a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
      b_key_valid = 0; b_key_in = '0; b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 0;
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;

      check1("rst_key_ready", a_key_ready, 1'b1);
      check1("rst_in_ready", a_in_ready, 1'b0);
      check1("rst_busy", a_busy, 1'b0);
      check1("rst_out_valid", a_out_valid, 1'b0);
      check1("rst_rnd_req", a_rnd_req, 1'b0);
      check64("rst_out_data", a_out_data, 64'h0);
      checki("rst_rnd_idx", int'(a_rnd_idx), 0);

      // Block offered with no key: never accepted.
      base = a_req_n;
      a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 64'h0;
      bad_r = 0;
      for (int c = 0; c < 3; c++) begin
         if (a_in_ready !== 1'b0) bad_r++;
         step();
      end
      checki("nokey_in_ready_cycles", bad_r, 0);
      check1("nokey_busy", a_busy, 1'b0);
      checki("nokey_rnd_req", a_req_n - base, 0);

      // Key and block in the same cycle: key loads, block waits one cycle.
      a_key_valid = 1'b1; a_key_in = key_a;
      step();
      a_key_valid = 1'b0;
      check1("samecyc_not_accepted", a_busy, 1'b0);
      check1("samecyc_key_loaded", a_in_ready, 1'b1);
      base = a_keys.size();
      run0(1'b0, 64'h0, 1'b1, res, lat);
      checki("samecyc_latency", lat, 32);
      check64("samecyc_enc0", res, enc0);
      checki("samecyc_keyseq", keyseq_errors(key_a, 1'b0, base), 0);

      for (int v = 0; v < 6; v++) begin
         base = a_keys.size();
         n = a_req_n;
         run0(vt[v].mode, vt[v].data, 1'b1, res, lat);
         check64($sformatf("vec%0d_data", v), res, vt[v].exp);
         checki($sformatf("vec%0d_latency", v), lat, 32);
         checki($sformatf("vec%0d_keyseq", v), keyseq_errors(key_a, vt[v].mode, base), 0);
         checki($sformatf("vec%0d_req_count", v), a_req_n - n, 32);
      end

      // Result held while out_ready low; key_valid while busy is ignored.
      exp = ref_block(key_a, 1'b0, 64'hDEADBEEFCAFEF00D);
      run0(1'b0, 64'hDEADBEEFCAFEF00D, 1'b0, res, lat);
      check64("hold_first", res, exp);
      bad_d = 0; bad_v = 0; bad_r = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin a_key_valid = 1'b1; a_key_in = ~key_a; end
         step();
         a_key_valid = 1'b0;
         if (a_out_data !== exp) bad_d++;
         if (a_out_valid !== 1'b1) bad_v++;
         if (a_in_ready !== 1'b0 || a_key_ready !== 1'b0) bad_r++;
      end
      checki("hold_data_unstable", bad_d, 0);
      checki("hold_valid_dropped", bad_v, 0);
      checki("hold_ready_high", bad_r, 0);
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      check1("hold_valid_cleared", a_out_valid, 1'b0);
      check1("hold_no_turnaround", a_busy, 1'b0);
      run0(1'b0, 64'hDEADBEEFCAFEF00D, 1'b1, res, lat);
      check64("hold_key_unchanged", res, exp);

      // Reset in the middle of round 17.
      a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 64'h0123456789ABCDEF;
      step();
      a_in_valid = 1'b0;
      n = 0;
      while (a_rnd_idx != 5'd17 && n < 100) begin step(); n++; end
      checki("midrst_reached_r17", int'(a_rnd_idx), 17);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check1("midrst_busy", a_busy, 1'b0);
      check1("midrst_out_valid", a_out_valid, 1'b0);
      check1("midrst_in_ready", a_in_ready, 1'b0);
      check1("midrst_key_ready", a_key_ready, 1'b1);
      checki("midrst_rnd_idx", int'(a_rnd_idx), 0);
      base = a_req_n;
      bad_v = 0;
      a_in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step();
         if (a_out_valid) bad_v++;
      end
      a_in_valid = 1'b0;
      checki("midrst_no_output", bad_v, 0);
      checki("midrst_no_req", a_req_n - base, 0);

      // Random key, random blocks.
      for (int i = 0; i < 8; i++) key_r[i*32 +: 32] = $urandom;
      load_key0(key_r);
      for (int v = 0; v < 4; v++) begin
         logic        m;
         logic [63:0] d;
         m = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         base = a_keys.size();
         run0(m, d, 1'b1, res, lat);
         check64($sformatf("rand%0d_data", v), res, ref_block(key_r, m, d));
         checki($sformatf("rand%0d_keyseq", v), keyseq_errors(key_r, m, base), 0);
      end

      // CORE_LAT=3 instance.
      b_key_valid = 1'b1; b_key_in = key_a;
      step();
      b_key_valid = 1'b0;
      b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = 64'h0123456789ABCDEF;
      step();
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 600) begin step(); lat++; end
      checki("lat3_latency", lat, 128);
      check64("lat3_data", b_out_data, ref_block(key_a, 1'b0, 64'h0123456789ABCDEF));
      checki("lat3_req_count", b_req_n, 32);
      checki("lat3_req_spacing", b_gap_bad, 0);
      checki("lat3_wait_stable", b_unstable, 0);
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
      check1("lat3_done", b_busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
